// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit:
// op encodings, FSM state type and cycle constants.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int ITER_CYCLES = 32;
  localparam int MDU_LATENCY = 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative datapath: shift-add multiply / restoring divide.
// load_i: clear acc, latch a_i/b_i; step_i: one iteration; acc_o: {hi,lo}.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   shr_q, shr_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rsh;
  logic [WIDTH+1:0]   diff;
  logic               take;

  // Upper-half add keeps its carry in bit WIDTH.
  assign sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, opb_q};
  // Partial remainder shifted left with next dividend bit.
  assign rsh  = {acc_q[2*WIDTH-1:WIDTH], shr_q[WIDTH-1]};
  assign diff = {1'b0, rsh} - {2'b00, opb_q};
  // A non-negative difference is always below the divisor,
  // so bit WIDTH is clear whenever the subtract succeeds.
  assign take = ~diff[WIDTH+1] & ~diff[WIDTH];

  always_comb begin
    acc_d = acc_q;
    shr_d = shr_q;
    opb_d = opb_q;
    if (load_i) begin
      acc_d = '0;
      shr_d = a_i;
      opb_d = b_i;
    end else if (step_i) begin
      if (div_i) begin
        acc_d = {(take ? diff[WIDTH-1:0] : rsh[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], take};
        shr_d = shr_q << 1;
      end else begin
        acc_d = shr_q[0] ? {sum, acc_q[WIDTH-1:1]}
                         : {1'b0, acc_q[2*WIDTH-1:1]};
        shr_d = shr_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      shr_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      shr_q <= shr_d;
      opb_q <= opb_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// MIPS HI/LO multiply/divide unit, fixed 34-cycle latency.
// start/op/rs/rt in; busy, hilo_write strobe, hi, lo out (all registered).
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             hilo_write,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER_CYCLES);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q;
  logic               sa_q, sb_q, dz_q;
  logic [WIDTH-1:0]   rs_q;
  logic               busy_q, hw_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept, sgn_op, sa, sb, neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign accept = (state_q == IDLE) & start;
  assign sgn_op = ~op[0];
  assign sa     = sgn_op & rs[WIDTH-1];
  assign sb     = sgn_op & rt[WIDTH-1];
  assign abs_a  = sa ? -rs : rs;
  assign abs_b  = sb ? -rt : rt;

  mdu_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .step_i (state_q == RUN),
    .div_i  (op_q[1]),
    .a_i    (abs_a),
    .b_i    (abs_b),
    .acc_o  (acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER_CYCLES - 1)) state_d = FIX;
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sign fix-up; sa_q/sb_q are zero for unsigned ops.
  assign neg  = sa_q ^ sb_q;
  assign prod = neg ? -acc : acc;
  assign quo  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = sa_q ? -acc[2*WIDTH-1:WIDTH]
                     : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (dz_q) begin
        res_hi = rs_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      rs_q    <= '0;
      busy_q  <= 1'b0;
      hw_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      hw_q    <= (state_d == DONE);
      if (accept) begin
        op_q <= op;
        sa_q <= sa;
        sb_q <= sb;
        dz_q <= op[1] & (rt == '0);
        rs_q <= rs;
      end
      if (state_q == FIX) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign busy       = busy_q;
  assign hilo_write = hw_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus
// handshake and mid-operation reset sequences.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] rs    = '0;
  logic [31:0] rt    = '0;
  logic        busy, hilo_write;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_div_unit #(
    .WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .busy       (busy),
    .hilo_write (hilo_write),
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic run_op(input int idx,
                        input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] eh,
                        input logic [31:0] el);
    int pulses;
    int pcyc;
    logic busy_ok;
    logic [31:0] gh, gl;
    pulses  = 0;
    pcyc    = -1;
    busy_ok = 1'b1;
    gh      = '0;
    gl      = '0;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    for (int k = 1; k <= MDU_LATENCY + 1; k++) begin
      @(negedge clk);
      if (busy !== (k <= MDU_LATENCY)) busy_ok = 1'b0;
      if (hilo_write === 1'b1) begin
        pulses++;
        pcyc = k;
        gh   = hi;
        gl   = lo;
      end
      if (k == 1) begin
        start = 1'b0;
        op    = 2'($urandom);
        rs    = $urandom;
        rt    = $urandom;
      end
    end
    chk($sformatf("v%0d strobe_cycle", idx),
        64'(pcyc), 64'(MDU_LATENCY));
    chk($sformatf("v%0d strobe_count", idx),
        64'(pulses), 64'd1);
    chk($sformatf("v%0d busy_window", idx),
        64'(busy_ok), 64'd1);
    chk($sformatf("v%0d hi", idx), 64'(gh), 64'(eh));
    chk($sformatf("v%0d lo", idx), 64'(gl), 64'(el));
    chk($sformatf("v%0d hi_held", idx),
        64'(hi), 64'(eh));
  endtask

  initial begin
    int stray;
    int hit34, hit69;
    logic [31:0] h34, l34, h69, l69;

    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{OP_MULT, 32'hFFFF_FFFD, 32'd7,
                 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{OP_MULT, 32'h8000_0000, 32'h8000_0000,
                 32'h4000_0000, 32'h0};
    vecs[3]  = '{OP_DIVU, 32'd100, 32'd7,
                 32'h2, 32'hE};
    vecs[4]  = '{OP_DIV, 32'hFFFF_FFF9, 32'd2,
                 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5]  = '{OP_DIV, 32'd7, 32'hFFFF_FFFE,
                 32'h1, 32'hFFFF_FFFD};
    vecs[6]  = '{OP_DIV, 32'h1234, 32'h0,
                 32'h1234, 32'hFFFF_FFFF};
    vecs[7]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'h0, 32'h8000_0000};
    vecs[8]  = '{OP_MULTU, 32'h1_0000, 32'h1_0000,
                 32'h1, 32'h0};
    vecs[9]  = '{OP_DIVU, 32'hFFFF_FFFF, 32'd1,
                 32'h0, 32'hFFFF_FFFF};
    vecs[10] = '{OP_DIVU, 32'd5, 32'd10,
                 32'h5, 32'h0};
    vecs[11] = '{OP_DIVU, 32'hABCD, 32'h0,
                 32'hABCD, 32'hFFFF_FFFF};
    vecs[12] = '{OP_MULTU, 32'hFFFF_FFFD, 32'd7,
                 32'h6, 32'hFFFF_FFEB};
    vecs[13] = '{OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE,
                 32'hFFFF_FFFF, 32'h3};
    vecs[14] = '{OP_DIVU, 32'hFFFF_FFF9, 32'd2,
                 32'h1, 32'h7FFF_FFFC};

    #2 rst_n = 1'b0;
    #10;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst hilo_write", 64'(hilo_write), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++)
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].eh, vecs[i].el);

    // Handshake: starts at 5 and 34 ignored, 35 taken.
    stray = 0;
    hit34 = 0;
    hit69 = 0;
    h34 = '0; l34 = '0; h69 = '0; l69 = '0;
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULTU;
    rs    = 32'hFFFF_FFFF;
    rt    = 32'hFFFF_FFFF;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (hilo_write === 1'b1) begin
        if (k == 34) begin
          hit34++; h34 = hi; l34 = lo;
        end else if (k == 69) begin
          hit69++; h69 = hi; l69 = lo;
        end else begin
          stray++;
        end
      end
      if (k == 35) chk("hs idle_at_35", 64'(busy), 64'd0);
      if (k == 36) chk("hs busy_at_36", 64'(busy), 64'd1);
      if (k == 50) chk("hs hi_hold", 64'(hi),
                       64'hFFFF_FFFE);
      start = 1'b0;
      if (k == 5) begin
        start = 1'b1; op = OP_DIVU;
        rs = 32'd100; rt = 32'd7;
      end
      if (k == 34) begin
        start = 1'b1; op = OP_DIV;
        rs = 32'h1234; rt = 32'h0;
      end
      if (k == 35) begin
        start = 1'b1; op = OP_DIVU;
        rs = 32'd100; rt = 32'd7;
      end
    end
    chk("hs stray_strobes", 64'(stray), 64'd0);
    chk("hs strobe_34", 64'(hit34), 64'd1);
    chk("hs hi_34", 64'(h34), 64'hFFFF_FFFE);
    chk("hs lo_34", 64'(l34), 64'h1);
    chk("hs strobe_69", 64'(hit69), 64'd1);
    chk("hs hi_69", 64'(h69), 64'h2);
    chk("hs lo_69", 64'(l69), 64'hE);

    // Mid-operation asynchronous reset at cycle 20.
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULTU;
    rs    = 32'hFFFF_FFFF;
    rt    = 32'hFFFF_FFFF;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mr busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr busy", 64'(busy), 64'd0);
    chk("mr hilo_write", 64'(hilo_write), 64'd0);
    chk("mr hi", 64'(hi), 64'd0);
    chk("mr lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (hilo_write !== 1'b0 || busy !== 1'b0) stray++;
    end
    chk("mr quiet_after", 64'(stray), 64'd0);
    run_op(100, OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit that produces the HI/LO results for the MIPS datapath. It accepts MULT, MULTU, DIV and DIVU operations with a start/busy handshake. After a fixed latency it drives the 32-bit HI and LO results with a one-cycle write strobe, which feeds the HI/LO register pair's `HI_input`, `LO_input` and `regWrite` inputs. The controller stalls HI/LO readers while `busy` is high.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported; the cycle counts below assume 32.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request an operation. Sampled only in IDLE.
- `op` in 2: operation. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs` in WIDTH: multiplicand or dividend. Sampled with `start`.
- `rt` in WIDTH: multiplier or divisor. Sampled with `start`.
- `busy` out 1: an operation is in flight. New `start` is ignored while high.
- `hilo_write` out 1: one-cycle strobe. `hi` and `lo` are valid in this cycle.
- `hi` out WIDTH: product[63:32] or remainder. Held until the next `hilo_write`.
- `lo` out WIDTH: product[31:0] or quotient. Held until the next `hilo_write`.

## Operation
- **FSM states: IDLE → RUN → FIX → DONE → IDLE.**
  - IDLE with `start`=1: latch `op`, |rs|, |rt| (absolute values only for signed ops), the sign bits and the raw `rs`. Clear the 64-bit accumulator. Count := 0.
  - RUN: one iteration per cycle for exactly 32 cycles.
    - Multiply: shift-add, one multiplier bit per cycle, LSB first.
    - Divide: restoring, one quotient bit per cycle, MSB first.
  - FIX: sign correction.
    - Signed multiply: negate the 64-bit product if the operand signs differ.
    - Signed divide: negate the quotient if the signs differ. The remainder takes the dividend's sign.
    - Unsigned ops pass through unchanged.
  - DONE: load `hi`/`lo` and assert `hilo_write` for this cycle only. Return to IDLE.
- **Divide by zero** (`rt`=0, DIV or DIVU): `lo`=0xFFFF_FFFF, `hi`=raw `rs`. Same latency as any other op. FIX is overridden.
- **Signed overflow** (DIV 0x8000_0000 / 0xFFFF_FFFF): `lo`=0x8000_0000, `hi`=0. This falls out of the abs/negate path with no special case.
- **Arithmetic:**
  - Multiply accumulator is 64-bit. Use a 33-bit add of the upper half to keep the carry.
  - Divide partial remainder is 33-bit. Subtract succeeds when the result is non-negative.
- **Reset values:** `busy`=0, `hilo_write`=0, `hi`=0, `lo`=0. State is IDLE.
- **Reset mid-operation:** abort immediately. No `hilo_write` is issued and the previous `hi`/`lo` are cleared to 0.
- `start` while `busy`: ignored, with no queuing. `start` in the DONE cycle is also ignored.
- `op`, `rs` and `rt` may change freely after the start cycle.

## Timing
- Cycle 0: `start`=1 in IDLE.
- Cycles 1–32: RUN, with `busy`=1.
- Cycle 33: FIX, with `busy`=1.
- Cycle 34: DONE, with `busy`=1, `hilo_write`=1 and `hi`/`lo` valid.
- Cycle 35: IDLE, `busy`=0. A new `start` is accepted here, giving a back-to-back throughput of one op per 35 cycles.
- Latency is fixed at 34 cycles from `start` to `hilo_write` for all ops, including divide by zero.
- `hi`/`lo` change only on the edge that enters DONE. They are stable at every other time.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- **Package `mdu_pkg`:**
  - Op encodings: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - FSM state enum: IDLE, RUN, FIX, DONE.
  - Constants: ITER_CYCLES=32, MDU_LATENCY=34.
- **Sub-module `mdu_iter_core`:** the iterative datapath, holding the accumulator, partial remainder and the one-step add/subtract.
- **Top level:** owns the FSM, the counter, operand abs/sign latching, FIX and the output registers.

## Test plan
- **Unsigned multiply:** MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → at cycle 34, `hi`=0xFFFF_FFFE, `lo`=0x0000_0001, `hilo_write` high for exactly one cycle, `busy` high in cycles 1–34.
- **Signed multiply:** MULT 0xFFFF_FFFD (−3) × 7 → `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFEB. Then MULT 0x8000_0000 × 0x8000_0000 → `hi`=0x4000_0000, `lo`=0.
- **Divide:**
  - DIVU 100 / 7 → `lo`=0xE, `hi`=0x2.
  - DIV 0xFFFF_FFF9 (−7) / 2 → `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF.
  - DIV 7 / 0xFFFF_FFFE (−2) → `lo`=0xFFFF_FFFD, `hi`=0x1.
- **Corner cases:**
  - DIV 0x1234 / 0 → `lo`=0xFFFF_FFFF, `hi`=0x1234 at cycle 34.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → `lo`=0x8000_0000, `hi`=0.
- **Handshake:** pulse `start` with different operands at cycles 5 and 34 → both ignored, and the original result appears at cycle 34. A `start` at cycle 35 is accepted and its result appears at cycle 69.
- **Reset mid-operation:** assert `rst_n`=0 asynchronously at cycle 20 of a MULTU → `busy`, `hi`, `lo` and `hilo_write` all go to 0 immediately. No `hilo_write` follows. After release, a fresh DIVU 9 / 3 gives `lo`=3, `hi`=0.
